// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - commit packet layout, arbiter state type and popcount helper
package vx_gpu_pkg;

  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 44;
  localparam int NW_WIDTH    = 2;
  localparam int NR_BITS     = 5;
  localparam int PID_WIDTH   = 1;

  localparam int COMMIT_DATAW = UUID_WIDTH + NW_WIDTH + NUM_THREADS + XLEN + 1 + NR_BITS
                              + NUM_THREADS * XLEN + 1 + PID_WIDTH + 1 + 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]             uuid;
    logic [NW_WIDTH-1:0]               wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [XLEN-1:0]                   pc;
    logic                              wb;
    logic [NR_BITS-1:0]                rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic                              tensor;
    logic [PID_WIDTH-1:0]              pid;
    logic                              sop;
    logic                              eop;
  } commit_data_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } commit_arb_state_t;

  function automatic logic [7:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + 8'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_commit_skid.sv
// rtl/vx_commit_skid.sv - 2-entry skid buffer; enq_ready depends on registered occupancy only
module vx_commit_skid #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [DATAW-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [DATAW-1:0] deq_data
);

  logic [DATAW-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Reset gates ready directly so no source is accepted while reset is held.
  assign enq_ready = reset && (count != 2'd2);
  assign deq_valid = (count != 2'd0);
  assign deq_data  = mem[rd_ptr];
  assign push      = enq_valid && enq_ready;
  assign pop       = deq_valid && deq_ready;

  // Pointer and occupancy tracking; reset drops any held entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/vx_commit_arb.sv
// rtl/vx_commit_arb.sv - round-robin commit arbiter locked over sop..eop, optional perf counters under VX_COMMIT_PERF_EN
module vx_commit_arb
  import vx_gpu_pkg::*;
#(
  parameter int NUM_EX        = 4,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_EX-1:0]              commit_in_valid,
  output logic [NUM_EX-1:0]              commit_in_ready,
  input  commit_data_t [NUM_EX-1:0]      commit_in_data,
  output logic                           commit_out_valid,
  input  logic                           commit_out_ready,
  output commit_data_t                   commit_out_data,
  output logic [PERF_CTR_BITS-1:0]       perf_commits,
  output logic [PERF_CTR_BITS-1:0]       perf_threads
);

  localparam int IW = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;

  commit_arb_state_t state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     next_ptr;
  logic              cand_found;
  logic              skid_ready;
  logic              xfer;
  commit_data_t      push_data;

  // Pick the candidate: the locked source, or the first valid source from rr_ptr onward.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand       = rr_ptr;
    idx        = 0;
    if (state == LOCKED) begin
      cand       = grant_idx;
      cand_found = commit_in_valid[grant_idx];
    end else begin
      for (int k = NUM_EX - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_EX) idx = idx - NUM_EX;
        if (commit_in_valid[idx]) begin
          cand       = IW'(idx);
          cand_found = 1'b1;
        end
      end
    end
  end

  // Only the candidate sees ready, and only when the skid buffer has room.
  always_comb begin
    for (int i = 0; i < NUM_EX; i++) begin
      commit_in_ready[i] = skid_ready && cand_found && (cand == IW'(i));
    end
  end

  assign xfer      = cand_found && skid_ready;
  assign push_data = commit_in_data[cand];
  assign next_ptr  = (cand == IW'(NUM_EX - 1)) ? '0 : cand + 1'b1;

  // Lock on a non-final packet; advance round-robin priority on eop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else if (xfer) begin
      if (push_data.eop) begin
        state  <= IDLE;
        rr_ptr <= next_ptr;
      end else begin
        state     <= LOCKED;
        grant_idx <= cand;
      end
    end
  end

  vx_commit_skid #(
    .DATAW (COMMIT_DATAW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (xfer),
    .enq_ready (skid_ready),
    .enq_data  (push_data),
    .deq_valid (commit_out_valid),
    .deq_ready (commit_out_ready),
    .deq_data  (commit_out_data)
  );

`ifdef VX_COMMIT_PERF_EN
  // Retired instruction and thread counters, counted at the output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_commits <= '0;
      perf_threads <= '0;
    end else if (commit_out_valid && commit_out_ready) begin
      perf_threads <= perf_threads + PERF_CTR_BITS'(popcount(commit_out_data.tmask));
      if (commit_out_data.eop) perf_commits <= perf_commits + 1'b1;
    end
  end
`else
  assign perf_commits = '0;
  assign perf_threads = '0;
`endif

`ifndef SYNTHESIS
  // A source holding valid must keep valid and data stable until it transfers.
  for (genvar g = 0; g < NUM_EX; g++) begin : g_proto
    a_hold : assert property (@(posedge clk) disable iff (!reset)
      (commit_in_valid[g] && !commit_in_ready[g]) |=> (commit_in_valid[g] && $stable(commit_in_data[g])))
      else $error("source %0d dropped or changed a pending packet", g);
  end
`endif

endmodule
